// File: rtl/cevero_dvfs_pkg.sv
// Shared types and helpers for the CEVERO DVFS governor.
package cevero_dvfs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_DECF   = 3'd2,
    ST_INCF   = 3'd3,
    ST_VREQ   = 3'd4,
    ST_SETTLE = 3'd5
  } dvfs_state_e;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_RAISE = 2'd1,
    ACT_LOWER = 2'd2
  } dvfs_action_e;

  // Number of set bits in a vector of up to 32 error sources
  function automatic logic [5:0] popcount(input logic [31:0] vec);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/cevero_dvfs_err_window.sv
// Window timer and saturating error accumulator; hands the completed window
// count to the governor and latches it on err_count_o at evaluation.
module cevero_dvfs_err_window
  import cevero_dvfs_pkg::*;
#(
  parameter int NumErrSrc = 4,
  parameter int CntWidth  = 8,
  parameter int WindowLen = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NumErrSrc-1:0] error_i,
  input  logic                 idle_i,
  input  logic                 count_en_i,
  input  logic                 eval_i,
  output logic                 window_done_o,
  output logic [CntWidth-1:0]  window_cnt_o,
  output logic [CntWidth-1:0]  err_count_o
);

  localparam int TW = (WindowLen > 1) ? $clog2(WindowLen) : 1;
  localparam int SW = CntWidth + 7;
  localparam logic [SW-1:0]       CNT_MAX   = {7'd0, {CntWidth{1'b1}}};
  localparam logic [TW-1:0]       TIMER_END = TW'(WindowLen - 1);
  localparam logic [TW-1:0]       TIMER_ONE = TW'(1);

  logic [TW-1:0]       timer_r;
  logic [CntWidth-1:0] cnt_r;
  logic [5:0]          pc_s;
  logic [SW-1:0]       acc_s;
  logic [SW-1:0]       load_s;
  logic [CntWidth-1:0] acc_sat_s;
  logic [CntWidth-1:0] load_sat_s;
  logic                timer_wrap_s;

  assign pc_s          = popcount(32'(error_i));
  assign timer_wrap_s  = (timer_r == TIMER_END);
  assign window_done_o = idle_i & enable_i & timer_wrap_s;
  assign window_cnt_o  = cnt_r;

  // Saturating accumulate and saturating reload values
  always_comb begin
    acc_s      = {7'd0, cnt_r} + SW'(pc_s);
    load_s     = SW'(pc_s);
    acc_sat_s  = {CntWidth{1'b1}};
    load_sat_s = {CntWidth{1'b1}};
    if (acc_s > CNT_MAX) begin
      acc_sat_s = {CntWidth{1'b1}};
    end else begin
      acc_sat_s = acc_s[CntWidth-1:0];
    end
    if (load_s > CNT_MAX) begin
      load_sat_s = {CntWidth{1'b1}};
    end else begin
      load_sat_s = load_s[CntWidth-1:0];
    end
  end

  // Window timer: runs only while idle and enabled, restarts after any sequence
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_r <= '0;
    end else if (!idle_i) begin
      timer_r <= '0;
    end else if (!enable_i) begin
      timer_r <= timer_r;
    end else if (timer_wrap_s) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TIMER_ONE;
    end
  end

  // Error accumulator; errors seen during an adjustment are discarded
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r       <= '0;
      err_count_o <= '0;
    end else if (!count_en_i) begin
      cnt_r <= '0;
    end else if (eval_i) begin
      cnt_r       <= load_sat_s;
      err_count_o <= cnt_r;
    end else begin
      cnt_r <= acc_sat_s;
    end
  end

endmodule

// File: rtl/cevero_dvfs_ctrl.sv
// Window-based DVFS governor: decides raise/lower/hold per error window and
// sequences frequency steps and the regulator req/ack voltage handshake.
module cevero_dvfs_ctrl
  import cevero_dvfs_pkg::*;
#(
  parameter int VoltWidth    = 3,
  parameter int FreqWidth    = 32,
  parameter int NumErrSrc    = 4,
  parameter int CntWidth     = 8,
  parameter int WindowLen    = 16,
  parameter int MaxErrors    = 3,
  parameter int OkWindows    = 10,
  parameter int MinVolt      = 0,
  parameter int MaxVolt      = 5,
  parameter int DefVolt      = 3,
  parameter int MinFreq      = 10,
  parameter int MaxFreq      = 100,
  parameter int FreqStep     = 10,
  parameter int SettleCycles = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NumErrSrc-1:0] error_i,
  input  logic                 volt_ack_i,
  output logic [VoltWidth-1:0] set_voltage_o,
  output logic [FreqWidth-1:0] set_freq_o,
  output logic                 volt_req_o,
  output logic [VoltWidth-1:0] volt_target_o,
  output logic                 busy_o,
  output logic [CntWidth-1:0]  err_count_o,
  output logic                 at_limit_o
);

  localparam int FW1 = FreqWidth + 1;
  localparam int STW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

  localparam logic [VoltWidth-1:0] V_MIN       = VoltWidth'(MinVolt);
  localparam logic [VoltWidth-1:0] V_MAX       = VoltWidth'(MaxVolt);
  localparam logic [VoltWidth-1:0] V_DEF       = VoltWidth'(DefVolt);
  localparam logic [VoltWidth-1:0] V_ONE       = VoltWidth'(1);
  localparam logic [FreqWidth-1:0] F_MIN       = FreqWidth'(MinFreq);
  localparam logic [FreqWidth-1:0] F_MAX       = FreqWidth'(MaxFreq);
  localparam logic [FreqWidth-1:0] F_STEP      = FreqWidth'(FreqStep);
  localparam logic [FW1-1:0]       F_MAX_W     = FW1'(MaxFreq);
  localparam logic [FW1-1:0]       F_STEP_W    = FW1'(FreqStep);
  localparam logic [FW1-1:0]       F_DEC_TH    = FW1'(MinFreq + FreqStep);
  localparam logic [CntWidth-1:0]  ERR_TH      = CntWidth'(MaxErrors);
  localparam logic [CntWidth-1:0]  OK_TH       = CntWidth'(OkWindows);
  localparam logic [CntWidth-1:0]  CNT_ONE     = CntWidth'(1);
  localparam logic [STW-1:0]       SETTLE_LAST = STW'(SettleCycles - 1);
  localparam logic [STW-1:0]       SETTLE_ONE  = STW'(1);

  dvfs_state_e         state_r;
  dvfs_action_e        action_s;
  logic [CntWidth-1:0] ok_cnt_r;
  logic [CntWidth-1:0] ok_inc_s;
  logic                quiet_s;
  logic                pend_r;
  logic [VoltWidth-1:0] pend_tgt_r;
  logic [STW-1:0]      settle_cnt_r;
  logic                window_done_s;
  logic [CntWidth-1:0] win_cnt_s;
  logic [FW1-1:0]      f_sum_s;
  logic [FreqWidth-1:0] f_inc_s;
  logic [FreqWidth-1:0] f_dec_s;
  logic                idle_s;
  logic                eval_s;
  logic                count_en_s;

  assign idle_s     = (state_r == ST_IDLE);
  assign eval_s     = (state_r == ST_EVAL);
  assign count_en_s = idle_s | eval_s;

  cevero_dvfs_err_window #(
    .NumErrSrc (NumErrSrc),
    .CntWidth  (CntWidth),
    .WindowLen (WindowLen)
  ) u_err_window (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .error_i       (error_i),
    .idle_i        (idle_s),
    .count_en_i    (count_en_s),
    .eval_i        (eval_s),
    .window_done_o (window_done_s),
    .window_cnt_o  (win_cnt_s),
    .err_count_o   (err_count_o)
  );

  // Window decision from the completed count and the quiet-window streak
  always_comb begin
    action_s = ACT_HOLD;
    quiet_s  = 1'b0;
    ok_inc_s = ok_cnt_r;
    if (ok_cnt_r != {CntWidth{1'b1}}) begin
      ok_inc_s = ok_cnt_r + CNT_ONE;
    end else begin
      ok_inc_s = ok_cnt_r;
    end
    if (win_cnt_s > ERR_TH) begin
      action_s = ACT_RAISE;
    end else if (win_cnt_s < ERR_TH) begin
      quiet_s = 1'b1;
      if (ok_inc_s >= OK_TH) begin
        action_s = ACT_LOWER;
      end else begin
        action_s = ACT_HOLD;
      end
    end else begin
      action_s = ACT_HOLD;
    end
  end

  // Clamped frequency steps; the up-step uses one extra bit so it cannot wrap
  always_comb begin
    f_sum_s = {1'b0, set_freq_o} + F_STEP_W;
    f_inc_s = F_MAX;
    f_dec_s = F_MIN;
    if (f_sum_s > F_MAX_W) begin
      f_inc_s = F_MAX;
    end else begin
      f_inc_s = f_sum_s[FreqWidth-1:0];
    end
    if ({1'b0, set_freq_o} >= F_DEC_TH) begin
      f_dec_s = set_freq_o - F_STEP;
    end else begin
      f_dec_s = F_MIN;
    end
  end

  // Governor FSM with registered V/F, handshake and status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      set_voltage_o <= V_DEF;
      set_freq_o    <= F_MAX;
      volt_target_o <= V_DEF;
      volt_req_o    <= 1'b0;
      busy_o        <= 1'b0;
      at_limit_o    <= 1'b0;
      ok_cnt_r      <= '0;
      pend_r        <= 1'b0;
      pend_tgt_r    <= V_DEF;
      settle_cnt_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_o <= 1'b0;
          if (window_done_s) begin
            state_r <= ST_EVAL;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          case (action_s)
            ACT_RAISE: begin
              ok_cnt_r <= '0;
              if (set_freq_o > F_MIN) begin
                state_r    <= ST_DECF;
                busy_o     <= 1'b1;
                at_limit_o <= 1'b0;
                pend_r     <= (set_voltage_o < V_MAX);
                pend_tgt_r <= set_voltage_o + V_ONE;
              end else if (set_voltage_o < V_MAX) begin
                state_r       <= ST_VREQ;
                busy_o        <= 1'b1;
                at_limit_o    <= 1'b0;
                volt_req_o    <= 1'b1;
                volt_target_o <= set_voltage_o + V_ONE;
              end else begin
                state_r    <= ST_IDLE;
                busy_o     <= 1'b0;
                at_limit_o <= 1'b1;
              end
            end
            ACT_LOWER: begin
              ok_cnt_r   <= '0;
              at_limit_o <= 1'b0;
              busy_o     <= 1'b1;
              if (set_voltage_o > V_MIN) begin
                state_r    <= ST_DECF;
                pend_r     <= 1'b1;
                pend_tgt_r <= set_voltage_o - V_ONE;
              end else begin
                state_r <= ST_INCF;
                pend_r  <= 1'b0;
              end
            end
            default: begin
              at_limit_o <= 1'b0;
              busy_o     <= 1'b0;
              state_r    <= ST_IDLE;
              if (quiet_s) begin
                ok_cnt_r <= ok_inc_s;
              end else begin
                ok_cnt_r <= ok_cnt_r;
              end
            end
          endcase
        end
        ST_DECF: begin
          set_freq_o <= f_dec_s;
          pend_r     <= 1'b0;
          if (pend_r) begin
            state_r       <= ST_VREQ;
            volt_req_o    <= 1'b1;
            volt_target_o <= pend_tgt_r;
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_INCF: begin
          set_freq_o <= f_inc_s;
          state_r    <= ST_SETTLE;
        end
        ST_VREQ: begin
          if (volt_ack_i) begin
            set_voltage_o <= volt_target_o;
            volt_req_o    <= 1'b0;
            state_r       <= ST_SETTLE;
          end else begin
            volt_req_o <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            settle_cnt_r <= '0;
            state_r      <= ST_IDLE;
            busy_o       <= 1'b0;
          end else begin
            settle_cnt_r <= settle_cnt_r + SETTLE_ONE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_o       <= 1'b0;
          volt_req_o   <= 1'b0;
          settle_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cevero_dvfs_ctrl.sv
// Directed bench for the DVFS governor with default parameters.
module tb_cevero_dvfs_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b1;
  logic [3:0]  error_i = 4'd0;
  logic        volt_ack_i = 1'b0;
  logic [2:0]  set_voltage_o;
  logic [31:0] set_freq_o;
  logic        volt_req_o;
  logic [2:0]  volt_target_o;
  logic        busy_o;
  logic [7:0]  err_count_o;
  logic        at_limit_o;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cyc;
  logic [2:0] req_tgt;

  int r_v   [7] = '{2, 1, 0, 0, 0, 0, 0};
  int r_f   [7] = '{90, 80, 70, 80, 90, 100, 100};
  int r_req [7] = '{3, 3, 3, 0, 0, 0, 0};

  cevero_dvfs_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .error_i       (error_i),
    .volt_ack_i    (volt_ack_i),
    .set_voltage_o (set_voltage_o),
    .set_freq_o    (set_freq_o),
    .volt_req_o    (volt_req_o),
    .volt_target_o (volt_target_o),
    .busy_o        (busy_o),
    .err_count_o   (err_count_o),
    .at_limit_o    (at_limit_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    volt_ack_i = 1'b0;
    error_i    = 4'd0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  // One full window from a window-start point: 16 idle cycles plus the eval cycle
  task automatic run_window(input int n_err, input logic [3:0] pat);
    for (int i = 0; i < 17; i++) begin
      error_i = (i < n_err) ? pat : 4'd0;
      @(negedge clk);
    end
    error_i = 4'd0;
  endtask

  // Drive an adjustment sequence to completion, acking on the third req cycle
  task automatic finish_seq(output int n_req, output logic [2:0] tgt);
    bit done;
    done  = 1'b0;
    n_req = 0;
    tgt   = 3'd0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (!busy_o) begin
        done = 1'b1;
      end else begin
        if (volt_req_o) begin
          n_req++;
          tgt = volt_target_o;
          if (n_req == 3) volt_ack_i = 1'b1;
        end
        @(negedge clk);
        volt_ack_i = 1'b0;
      end
    end
    check_eq("seq_done", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset values
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_v",    32'(set_voltage_o), 32'd3);
    check_eq("rst_f",    set_freq_o,         32'd100);
    check_eq("rst_req",  32'(volt_req_o),    32'd0);
    check_eq("rst_tgt",  32'(volt_target_o), 32'd3);
    check_eq("rst_busy", 32'(busy_o),        32'd0);
    check_eq("rst_err",  32'(err_count_o),   32'd0);
    check_eq("rst_lim",  32'(at_limit_o),    32'd0);
    rst_i = 1'b0;
    run_window(0, 4'd0);
    check_eq("q0_busy", 32'(busy_o),        32'd0);
    check_eq("q0_err",  32'(err_count_o),   32'd0);
    check_eq("q0_v",    32'(set_voltage_o), 32'd3);
    check_eq("q0_f",    set_freq_o,         32'd100);

    // quiet rounds: lower V with F step, then INCF, then clamp at MaxFreq
    do_reset();
    for (int r = 0; r < 7; r++) begin
      for (int w = 0; w < 9; w++) run_window(0, 4'd0);
      if (r == 0) begin
        run_window(3, 4'b0001);
        check_eq("hold_busy", 32'(busy_o),        32'd0);
        check_eq("hold_err",  32'(err_count_o),   32'd3);
        check_eq("hold_v",    32'(set_voltage_o), 32'd3);
      end
      run_window(0, 4'd0);
      check_eq("low_busy", 32'(busy_o), 32'd1);
      finish_seq(req_cyc, req_tgt);
      check_eq("low_v",   32'(set_voltage_o), 32'(r_v[r]));
      check_eq("low_f",   set_freq_o,         32'(r_f[r]));
      check_eq("low_req", 32'(req_cyc),       32'(r_req[r]));
      if (r_req[r] > 0) check_eq("low_tgt", 32'(req_tgt), 32'(r_v[r]));
    end

    // exact timing of the first raise sequence
    do_reset();
    for (int i = 0; i < 16; i++) begin
      error_i = (i < 5) ? 4'b0001 : 4'b0000;
      @(negedge clk);
    end
    check_eq("b_eval_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check_eq("b_decf_busy", 32'(busy_o),      32'd1);
    check_eq("b_err",       32'(err_count_o), 32'd5);
    check_eq("b_f_pre",     set_freq_o,       32'd100);
    @(negedge clk);
    check_eq("b_f",   set_freq_o,         32'd90);
    check_eq("b_req", 32'(volt_req_o),    32'd1);
    check_eq("b_tgt", 32'(volt_target_o), 32'd4);
    @(negedge clk);
    check_eq("b_req2", 32'(volt_req_o), 32'd1);
    @(negedge clk);
    check_eq("b_req3", 32'(volt_req_o), 32'd1);
    volt_ack_i = 1'b1;
    @(negedge clk);
    volt_ack_i = 1'b0;
    check_eq("b_v",        32'(set_voltage_o), 32'd4);
    check_eq("b_req_drop", 32'(volt_req_o),    32'd0);
    check_eq("b_settle",   32'(busy_o),        32'd1);
    repeat (7) @(negedge clk);
    check_eq("b_settle_end", 32'(busy_o), 32'd1);
    @(negedge clk);
    check_eq("b_idle", 32'(busy_o), 32'd0);

    // four simultaneous errors raise again
    run_window(1, 4'b1111);
    check_eq("c_busy", 32'(busy_o),      32'd1);
    check_eq("c_err",  32'(err_count_o), 32'd4);
    finish_seq(req_cyc, req_tgt);
    check_eq("c_req", 32'(req_cyc),       32'd3);
    check_eq("c_tgt", 32'(req_tgt),       32'd5);
    check_eq("c_v",   32'(set_voltage_o), 32'd5);
    check_eq("c_f",   set_freq_o,         32'd80);

    // exactly MaxErrors holds
    run_window(3, 4'b0001);
    check_eq("d_busy", 32'(busy_o),        32'd0);
    check_eq("d_err",  32'(err_count_o),   32'd3);
    check_eq("d_v",    32'(set_voltage_o), 32'd5);
    check_eq("d_f",    set_freq_o,         32'd80);

    // raises at MaxVolt only step frequency down to MinFreq
    for (int k = 0; k < 7; k++) begin
      run_window(1, 4'b1111);
      check_eq("r_busy", 32'(busy_o), 32'd1);
      finish_seq(req_cyc, req_tgt);
      check_eq("r_req", 32'(req_cyc),       32'd0);
      check_eq("r_f",   set_freq_o,         32'(70 - 10 * k));
      check_eq("r_v",   32'(set_voltage_o), 32'd5);
    end
    run_window(1, 4'b1111);
    check_eq("lim_set",  32'(at_limit_o),    32'd1);
    check_eq("lim_busy", 32'(busy_o),        32'd0);
    check_eq("lim_req",  32'(volt_req_o),    32'd0);
    check_eq("lim_v",    32'(set_voltage_o), 32'd5);
    check_eq("lim_f",    set_freq_o,         32'd10);
    run_window(0, 4'd0);
    check_eq("lim_clr",  32'(at_limit_o),  32'd0);
    check_eq("lim_err",  32'(err_count_o), 32'd0);

    // reset during an open request, then a stale ack
    do_reset();
    run_window(1, 4'b1111);
    check_eq("g_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    check_eq("g_req", 32'(volt_req_o),    32'd1);
    check_eq("g_tgt", 32'(volt_target_o), 32'd4);
    check_eq("g_f",   set_freq_o,         32'd90);
    rst_i = 1'b1;
    #1;
    check_eq("g_rst_req",  32'(volt_req_o),    32'd0);
    check_eq("g_rst_v",    32'(set_voltage_o), 32'd3);
    check_eq("g_rst_f",    set_freq_o,         32'd100);
    check_eq("g_rst_busy", 32'(busy_o),        32'd0);
    volt_ack_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("g_late_v",    32'(set_voltage_o), 32'd3);
    check_eq("g_late_req",  32'(volt_req_o),    32'd0);
    check_eq("g_late_busy", 32'(busy_o),        32'd0);
    volt_ack_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cevero_dvfs_ctrl.md
Name: cevero_dvfs_ctrl

Overview:
Parametrised, window-based DVFS governor for a CEVERO core. Errors from several detector sources are combined and counted over a fixed window. Each window drives one raise-performance-margin, lower-power or hold decision. Voltage changes go through a req/ack handshake with the external regulator and are followed by a settle period. Frequency is written directly to the clock generator via set_freq_o.

Parameters:
VoltWidth, 3, width of voltage code
FreqWidth, 32, width of frequency word
NumErrSrc, 4, number of error source bits
CntWidth, 8, error/ok counter width (saturating)
WindowLen, 16, evaluation window length in cycles
MaxErrors, 3, error threshold per window
OkWindows, 10, consecutive quiet windows before lowering
MinVolt, 0 / MaxVolt, 5 / DefVolt, 3, voltage code bounds and reset value
MinFreq, 10 / MaxFreq, 100 / FreqStep, 10, frequency bounds (MaxFreq is also the reset value) and step
SettleCycles, 8, cycles waited after any V/F change

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
enable_i  in  1  governor enable
error_i  in  NumErrSrc  per-source error pulses, one count per set bit per cycle
volt_ack_i  in  1  regulator acknowledge
set_voltage_o  out  VoltWidth  applied voltage code
set_freq_o  out  FreqWidth  applied frequency
volt_req_o  out  1  voltage change request
volt_target_o  out  VoltWidth  requested voltage code
busy_o  out  1  adjustment sequence in progress (state not IDLE/EVAL)
err_count_o  out  CntWidth  error count of last completed window
at_limit_o  out  1  raise required but V=MaxVolt and F=MinFreq

Behaviour:
- Reset (async, rst_i high): state IDLE; set_voltage_o=DefVolt; set_freq_o=MaxFreq; volt_target_o=DefVolt; volt_req_o=0; busy_o=0; err_count_o=0; at_limit_o=0; all counters 0.
- States: IDLE, EVAL, DECF, INCF, VREQ, SETTLE.
- IDLE: if enable_i, the window timer increments. At timer==WindowLen-1, the timer clears and next state is EVAL. If enable_i=0, the timer and ok counter hold.
- Error counter:
  - Adds popcount(error_i) each cycle in IDLE and EVAL; saturates at 2^CntWidth-1.
  - In EVAL it reloads with popcount(error_i) of that cycle, and the old value is copied to err_count_o.
  - In DECF/INCF/VREQ/SETTLE it is held at 0, so transients from adjustments are discarded.
- EVAL (one cycle), using err = completed window count:
  - err > MaxErrors (raise):
    - ok counter cleared.
    - If F>MinFreq: go DECF, then VREQ with target V+1 if V<MaxVolt.
    - Else if V<MaxVolt: go VREQ with target V+1.
    - Else (F=MinFreq and V=MaxVolt): at_limit_o=1, go IDLE.
  - err < MaxErrors (quiet): ok counter increments, saturating.
    - If it reaches OkWindows (lower): ok counter cleared.
    - If V>MinVolt: DECF then VREQ with target V-1.
    - Else: INCF.
    - If OkWindows is not reached: IDLE.
  - err == MaxErrors: ok counter held; go IDLE.
  - at_limit_o is cleared in any EVAL that is not a blocked raise.
- DECF: set_freq_o = max(F-FreqStep, MinFreq), computed without underflow.
  - Next state is VREQ if a voltage step is pending, else SETTLE.
- INCF: set_freq_o = min(F+FreqStep, MaxFreq), computed in FreqWidth+1 bits; next state SETTLE.
- VREQ handshake:
  - volt_target_o is registered on VREQ entry.
  - volt_req_o is high for every VREQ cycle; volt_target_o is stable while req is high.
  - On the cycle volt_ack_i=1: set_voltage_o<=volt_target_o, next state SETTLE, and volt_req_o is 0 from the next cycle.
  - volt_ack_i outside VREQ is ignored. There is no timeout.
- SETTLE: counts SettleCycles cycles, then IDLE. The window timer restarts at 0.
- Disabling enable_i mid-sequence does not abort; the sequence completes and then the block waits in IDLE.
- Reset mid-handshake drops volt_req_o immediately; the regulator must tolerate a withdrawn request.
- Voltage never leaves [MinVolt,MaxVolt]; frequency never leaves [MinFreq,MaxFreq].

Decomposition:
- Package cevero_dvfs_pkg: state enum dvfs_state_e, decision enum dvfs_action_e {ACT_HOLD, ACT_RAISE, ACT_LOWER}, and a popcount function.
- Sub-module cevero_dvfs_err_window: window timer, popcount, saturating error counter, window-done pulse and err_count_o register.
- Top level: FSM, ok counter, V/F registers, handshake.

Test Plan:
- Reset release, no errors, enable_i=1 -> V=3, F=100, volt_req_o=0; first EVAL occurs 16 cycles after release; err_count_o=0.
- 5 single-bit error pulses in window 1 -> F 100->90 in DECF; volt_req_o=1 with target 4; volt_ack_i given after 3 cycles -> V=4 on the ack cycle; busy_o held high through 8 SETTLE cycles; err_count_o=5.
- error_i=4'b1111 for one cycle -> counted 4 > 3 -> raise sequence. Exactly 3 errors -> hold, no change, ok counter unchanged.
- Quiet windows:
  - 10 quiet windows from V=1, F=100 -> F=90, then V=0 via handshake.
  - 10 further quiet windows -> INCF, F=100.
  - 10 more -> F stays 100 (clamp).
- Preload V=5, F=10 via a raise sequence, then force a window with >3 errors -> at_limit_o=1, no volt_req_o; a following quiet window clears at_limit_o.
- Assert rst_i while volt_req_o=1 -> volt_req_o=0 in the same cycle, V=3, F=100. A late volt_ack_i after reset has no effect.
